// File: rtl/lsu_rmw_ctrl_if.sv
// LSU load/store sequencer bus bundle: pipeline request, data memory port,
// store-data rewrite stage port and completion status. The sequencer uses the
// slave modport; the surrounding pipeline/memory side uses master.
interface lsu_rmw_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // pipeline request
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [ADDR_W-1:0] i_addr;
    logic [1:0]        i_st_type;
    logic [31:0]       i_st_data;
    // synchronous data memory
    logic [ADDR_W-3:0] o_mem_addr;
    logic              o_mem_re;
    logic              o_mem_we;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;
    // store-data rewrite stage
    logic [31:0]       o_rw_ld_data;
    logic [1:0]        o_rw_addr_segment;
    logic [1:0]        o_rw_st_type;
    logic [31:0]       o_rw_st_data;
    logic [31:0]       i_rw_new_data;
    // completion
    logic              o_done;
    logic              o_err;
    logic [31:0]       o_ld_data;

    modport slave (
        input  i_req_valid, i_req_we, i_addr, i_st_type, i_st_data,
        input  i_mem_rdata, i_rw_new_data,
        output o_req_ready,
        output o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
        output o_rw_ld_data, o_rw_addr_segment, o_rw_st_type, o_rw_st_data,
        output o_done, o_err, o_ld_data
    );

    modport master (
        output i_req_valid, i_req_we, i_addr, i_st_type, i_st_data,
        output i_mem_rdata, i_rw_new_data,
        input  o_req_ready,
        input  o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
        input  o_rw_ld_data, o_rw_addr_segment, o_rw_st_type, o_rw_st_data,
        input  o_done, o_err, o_ld_data
    );
endinterface

// File: rtl/lsu_rmw_ctrl.sv
// LSU load/store sequencer. Sub-word stores run read-modify-write through the
// external rewrite stage; loads and word stores take shorter paths; illegal or
// misaligned requests are answered with o_err and never touch memory.
// Optional macro RMW_FWD_EN adds a last-written-word buffer that lets loads and
// sub-word stores to the most recently written word skip the memory read.
module lsu_rmw_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lsu_rmw_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_MRG  = 3'd3,
        S_WR   = 3'd4,
        S_RESP = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        st_type_q, st_type_d;
    logic [31:0]       st_data_q, st_data_d;
    logic              err_q, err_d;
    logic [31:0]       ld_word_q, ld_word_d;
    logic [31:0]       wdata_q, wdata_d;

`ifdef RMW_FWD_EN
    logic              fwd_vld_q, fwd_vld_d;
    logic [ADDR_W-3:0] fwd_addr_q, fwd_addr_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
`endif

    logic accept;
    logic req_err;
    logic req_word_st;
    logic req_hit;

    // Decode the incoming request: acceptance, legality, path selection.
    always_comb begin
        accept      = bus.i_req_valid && (state_q == S_IDLE);
        req_word_st = bus.i_req_we && (bus.i_st_type == 2'd2);
        unique case (bus.i_st_type)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = bus.i_addr[0];
            2'd2:    req_err = (bus.i_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
`ifdef RMW_FWD_EN
        req_hit = fwd_vld_q && (fwd_addr_q == bus.i_addr[ADDR_W-1:2])
                  && !req_err && !req_word_st;
`else
        req_hit = 1'b0;
`endif
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)          state_d = S_RESP;
                    else if (req_word_st) state_d = S_WR;
                    else if (req_hit)     state_d = bus.i_req_we ? S_MRG : S_RESP;
                    else                  state_d = S_RD;
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = we_q ? S_MRG : S_RESP;
            S_MRG:   state_d = S_WR;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath register updates: request capture, old-word capture, merged word.
    always_comb begin
        addr_d    = addr_q;
        we_d      = we_q;
        st_type_d = st_type_q;
        st_data_d = st_data_q;
        err_d     = err_q;
        ld_word_d = ld_word_q;
        wdata_d   = wdata_q;
`ifdef RMW_FWD_EN
        fwd_vld_d  = fwd_vld_q;
        fwd_addr_d = fwd_addr_q;
        fwd_data_d = fwd_data_q;
`endif
        if (accept) begin
            addr_d    = bus.i_addr;
            we_d      = bus.i_req_we;
            st_type_d = bus.i_st_type;
            st_data_d = bus.i_st_data;
            err_d     = req_err;
            if (req_word_st && !req_err) wdata_d = bus.i_st_data;
`ifdef RMW_FWD_EN
            if (req_hit) ld_word_d = fwd_data_q;
`endif
        end
        if (state_q == S_CAP) ld_word_d = bus.i_mem_rdata;
        if (state_q == S_MRG) wdata_d = bus.i_rw_new_data;
`ifdef RMW_FWD_EN
        if (state_q == S_WR) begin
            fwd_vld_d  = 1'b1;
            fwd_addr_d = addr_q[ADDR_W-1:2];
            fwd_data_d = wdata_q;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            st_type_q <= '0;
            st_data_q <= '0;
            err_q     <= 1'b0;
            ld_word_q <= '0;
            wdata_q   <= '0;
`ifdef RMW_FWD_EN
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            st_type_q <= st_type_d;
            st_data_q <= st_data_d;
            err_q     <= err_d;
            ld_word_q <= ld_word_d;
            wdata_q   <= wdata_d;
`ifdef RMW_FWD_EN
            fwd_vld_q  <= fwd_vld_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
`endif
        end
    end

    // Outputs decoded from state; data outputs come straight from registers.
    always_comb begin
        bus.o_req_ready       = (state_q == S_IDLE);
        bus.o_mem_re          = (state_q == S_RD);
        bus.o_mem_we          = (state_q == S_WR);
        bus.o_done            = (state_q == S_RESP);
        bus.o_err             = (state_q == S_RESP) && err_q;
        bus.o_mem_addr        = addr_q[ADDR_W-1:2];
        bus.o_mem_wdata       = wdata_q;
        bus.o_rw_ld_data      = ld_word_q;
        bus.o_rw_addr_segment = addr_q[1:0];
        bus.o_rw_st_type      = st_type_q;
        bus.o_rw_st_data      = st_data_q;
        bus.o_ld_data         = ld_word_q;
    end

endmodule
